alu_arbiter: RTL and testbench

Round-robin arbiter that shares one combinational ALU between `N_REQ` requesters. It accepts at most one operation per cycle through a valid/ready handshake and registers the ALU result with the winning requester's ID. It presents that result on a single response port with backpressure. The block sits between the issue logic of several clients (decode, address-gen, debug) and the shared `ALU` unit.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/ALU.sv | 39 +++
 rtl/alu_arbiter.sv | 105 ++++++++++
 tb/tb_alu_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode encodings, datapath widths and the opcode
// legality helper used by the ALU and the requester arbiter.
package alu_pkg;

  localparam int unsigned ALU_W    = 32;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned SHAMT_W  = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_NOT = 4'd6,
    OP_SLL = 4'd7,
    OP_SRL = 4'd8,
    OP_SRA = 4'd9,
    OP_ROL = 4'd10
  } alu_op_t;

  // Legal opcodes form the contiguous range ADD..ROL; 0 and 11..15 are illegal.
  function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
    return (op != '0) && (op <= ALU_OP_W'(OP_ROL));
  endfunction

endpackage

// File: rtl/ALU.sv
// ALU: purely combinational 32-bit ALU shared by the arbiter.
//   alu_op : opcode (alu_pkg::alu_op_t encoding)
//   A, B   : operands; shifts and rotates use B[4:0], NOT ignores B
//   result : operation result, 0 for illegal opcodes
module ALU
  import alu_pkg::*;
(
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [ALU_W-1:0]    A,
  input  logic [ALU_W-1:0]    B,
  output logic [ALU_W-1:0]    result
);

  logic [SHAMT_W-1:0] shamt;
  logic [SHAMT_W:0]   rol_rsh;

  assign shamt   = B[SHAMT_W-1:0];
  // Rotate-left = (A << s) | (A >> (32 - s)); s=0 shifts right by 32, giving 0.
  assign rol_rsh = (SHAMT_W+1)'(ALU_W) - (SHAMT_W+1)'(shamt);

  // Opcode decode
  always_comb begin
    result = '0;
    case (alu_op_t'(alu_op))
      OP_ADD:  result = A + B;
      OP_SUB:  result = A - B;
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_NOT:  result = ~A;
      OP_SLL:  result = A << shamt;
      OP_SRL:  result = A >> shamt;
      OP_SRA:  result = ALU_W'($unsigned($signed(A) >>> shamt));
      OP_ROL:  result = (A << shamt) | (A >> rol_rsh);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between
// N_REQ requesters, with a registered single-entry response port.
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/req_ready: per-requester handshake (at most one ready bit high)
//   req_op/req_a/req_b : per-requester opcode and operands
//   rsp_valid/rsp_ready: response handshake with backpressure
//   rsp_data/rsp_id    : registered ALU result and issuing requester index
//   rsp_err            : opcode was illegal (rsp_data is then 0)
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_REQ-1:0]                   req_valid,
  output logic [N_REQ-1:0]                   req_ready,
  input  logic [N_REQ-1:0][ALU_OP_W-1:0]     req_op,
  input  logic [N_REQ-1:0][ALU_W-1:0]        req_a,
  input  logic [N_REQ-1:0][ALU_W-1:0]        req_b,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [ALU_W-1:0]                   rsp_data,
  output logic [ID_W-1:0]                    rsp_id,
  output logic                               rsp_err
);

  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     winner;
  logic [ID_W-1:0]     rr_next;
  logic                any_valid;
  logic                can_issue;
  logic                issue;
  logic [ALU_OP_W-1:0] sel_op;
  logic [ALU_W-1:0]    sel_a;
  logic [ALU_W-1:0]    sel_b;
  logic [ALU_W-1:0]    alu_result;
  logic                sel_err;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned cand;
    winner    = '0;
    any_valid = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!any_valid && req_valid[ID_W'(cand)]) begin
        any_valid = 1'b1;
        winner    = ID_W'(cand);
      end
    end
  end

  // A new op may enter whenever the response slot is empty or draining.
  assign can_issue = !rsp_valid || rsp_ready;
  assign issue     = !rst && any_valid && can_issue;

  // Grant only the winner; nothing is accepted during reset.
  always_comb begin
    req_ready = '0;
    if (issue) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign rr_next = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);

  // Winner payload routed to the shared ALU
  assign sel_op  = req_op[winner];
  assign sel_a   = req_a[winner];
  assign sel_b   = req_b[winner];
  assign sel_err = !alu_op_legal(sel_op);

  ALU u_alu (
    .alu_op (sel_op),
    .A      (sel_a),
    .B      (sel_b),
    .result (alu_result)
  );

  // Response register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      rr_ptr    <= '0;
    end else if (issue) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_result;
      rsp_id    <= winner;
      rsp_err   <= sel_err;
      rr_ptr    <= rr_next;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter (N_REQ=2) with a scoreboard
// of expected responses pushed at issue and compared when presented.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned IW = 1;

  typedef struct packed {
    logic [31:0]   data;
    logic [IW-1:0] id;
    logic          err;
  } rsp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [N-1:0][3:0]     req_op;
  logic [N-1:0][31:0]    req_a;
  logic [N-1:0][31:0]    req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic [IW-1:0]         rsp_id;
  logic                  rsp_err;

  rsp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned m_rr     = 0;
  logic        m_valid  = 1'b0;
  int          last_win = -1;

  alu_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference ALU built from single-bit shift steps
  function automatic rsp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int id);
    logic [31:0] r;
    logic        e;
    int          s;
    r = 32'h0;
    e = 1'b0;
    s = int'(b[4:0]);
    case (op)
      4'd1:  r = a + b;
      4'd2:  r = a - b;
      4'd3:  r = a & b;
      4'd4:  r = a | b;
      4'd5:  r = a ^ b;
      4'd6:  r = ~a;
      4'd7:  begin r = a; repeat (s) r = {r[30:0], 1'b0}; end
      4'd8:  begin r = a; repeat (s) r = {1'b0, r[31:1]}; end
      4'd9:  begin r = a; repeat (s) r = {r[31], r[31:1]}; end
      4'd10: begin r = a; repeat (s) r = {r[30:0], r[31]}; end
      default: e = 1'b1;
    endcase
    return '{data: r, id: IW'(id), err: e};
  endfunction

  task automatic drive(input int i, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    req_valid[IW'(i)] = 1'b1;
    req_op[IW'(i)]    = op;
    req_a[IW'(i)]     = a;
    req_b[IW'(i)]     = b;
  endtask

  // One clock: check response and grant at negedge, update model after posedge.
  task automatic step();
    int           win;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        chk("rsp_data", rsp_data, sb[0].data);
        chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
        chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
        if (rsp_ready) void'(sb.pop_front());
      end
    end
    win = -1;
    exp_ready = '0;
    if (!rst && (!m_valid || rsp_ready)) begin
      for (int k = 0; k < int'(N); k++) begin
        int idx;
        idx = (int'(m_rr) + k) % int'(N);
        if (win < 0 && req_valid[IW'(idx)]) win = idx;
      end
    end
    if (win >= 0) exp_ready[IW'(win)] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    last_win = win;
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      m_valid = 1'b0;
      m_rr    = 0;
    end else if (win >= 0) begin
      sb.push_back(model(req_op[IW'(win)], req_a[IW'(win)], req_b[IW'(win)], win));
      m_valid = 1'b1;
      m_rr    = 32'((win + 1) % int'(N));
      req_valid[IW'(win)] = 1'b0;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // Reset state
    step();
    rst = 1'b0;
    chk("reset_rsp_data", rsp_data, 32'h0);
    chk("reset_rsp_id", 32'(rsp_id), 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);
    step();

    // Single issue with wraparound add
    rsp_ready = 1'b1;
    drive(0, 4'd1, 32'hFFFF_FFFF, 32'h1);
    step();
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_data", rsp_data, 32'h0);
    chk("t1_id", 32'(rsp_id), 32'h0);
    step();

    // Realign pointer to 0, then both requesters continuously valid
    drive(1, 4'd5, 32'hF0F0_0000, 32'h0F0F_0000);
    step();
    drive(0, 4'd3, 32'h1234_5678, 32'h0000_FFFF);
    drive(1, 4'd2, 32'd100, 32'd30);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_order", 32'(last_win), 32'(exp_order[k]));
      if (!req_valid[0]) drive(0, 4'(3 + k), 32'hA5A5_0000 + 32'(k), 32'h0000_5A5A);
      if (!req_valid[1]) drive(1, 4'(7 + (k % 3)), 32'h8000_00F0, 32'(k + 1));
    end
    req_valid = '0;
    step();
    step();

    // Backpressure: stall three cycles, then consume and issue together
    drive(0, 4'd4, 32'h0000_00F0, 32'h0000_000F);
    step();
    rsp_ready = 1'b0;
    drive(1, 4'd7, 32'h0000_0001, 32'h0000_0004);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_ready", 32'(req_ready), 32'h0);
      chk("stall_data", rsp_data, 32'h0000_00FF);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_valid_kept", 32'(rsp_valid), 32'd1);
    chk("bp_new_data", rsp_data, 32'h0000_0010);
    chk("bp_new_id", 32'(rsp_id), 32'd1);
    step();

    // Operation corners
    drive(0, 4'd10, 32'h8000_0001, 32'h0);
    step();
    chk("rol0", rsp_data, 32'h8000_0001);
    drive(0, 4'd10, 32'h8000_0001, 32'h1);
    step();
    chk("rol1", rsp_data, 32'h0000_0003);
    drive(0, 4'd9, 32'h8000_0000, 32'h24);
    step();
    chk("sra4", rsp_data, 32'hF800_0000);
    drive(0, 4'd2, 32'h0, 32'h1);
    step();
    chk("sub", rsp_data, 32'hFFFF_FFFF);

    // Illegal opcodes
    drive(1, 4'd0, 32'h1111_1111, 32'h2222_2222);
    step();
    chk("ill0_err", 32'(rsp_err), 32'd1);
    chk("ill0_data", rsp_data, 32'h0);
    chk("ill0_id", 32'(rsp_id), 32'd1);
    drive(0, 4'd15, 32'h3333_3333, 32'h4444_4444);
    step();
    chk("ill15_err", 32'(rsp_err), 32'd1);
    chk("ill15_data", rsp_data, 32'h0);
    chk("ill15_id", 32'(rsp_id), 32'd0);
    step();

    // Reset while a response is stalled
    drive(1, 4'd1, 32'd5, 32'd6);
    step();
    rsp_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", 32'(rsp_valid), 32'h0);
    chk("rst_mid_data", rsp_data, 32'h0);
    chk("rst_mid_id", 32'(rsp_id), 32'h0);
    chk("rst_mid_err", 32'(rsp_err), 32'h0);
    rsp_ready = 1'b1;
    drive(0, 4'd1, 32'd7, 32'd8);
    drive(1, 4'd1, 32'd9, 32'd10);
    step();
    chk("post_rst_grant", 32'(last_win), 32'd0);
    step();
    chk("post_rst_grant2", 32'(last_win), 32'd1);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
